// File: rtl/multicycle_ctrl_if.sv
// Memory and IR port of the multi-cycle controller.
// master = controller side, slave = memory side.
interface multicycle_ctrl_if;
    logic memread;
    logic memwrite;
    logic iord;
    logic irwrite;
    logic memsize;
    logic mem_ready;

    modport master (
        output memread, memwrite, iord,
        output irwrite, memsize,
        input  mem_ready
    );

    modport slave (
        input  memread, memwrite, iord,
        input  irwrite, memsize,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM with memory-ready
// handshake, bus timeout and trap state.
module multicycle_ctrl #(
    parameter int TIMEOUT_W     = 4,
    parameter int TIMEOUT       = 15,
    parameter int MEM_HANDSHAKE = 1
) (
    input  logic              clk,
    input  logic              rst,
    multicycle_ctrl_if.master mem,
    input  logic [5:0]        op_i,
    input  logic              zero_i,
    output logic              alusrca_o,
    output logic [2:0]        alusrcb_o,
    output logic [1:0]        aluop_o,
    output logic [1:0]        pcsource_o,
    output logic              regwrite_o,
    output logic              regdst_o,
    output logic              memtoreg_o,
    output logic              link_o,
    output logic              bne_o,
    output logic              j_o,
    output logic              pcen_o,
    output logic              trap_o,
    output logic [1:0]        cause_o
);
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LB   = 6'b100000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SB   = 6'b101000;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [1:0] CAUSE_ILL = 2'b01;
    localparam logic [1:0] CAUSE_BUS = 2'b10;

    localparam logic [TIMEOUT_W-1:0] TMO =
        TIMEOUT_W'(TIMEOUT);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB,
        MEMWR, RTEX, RTWB, IMMEX, IMMWB,
        BEQEX, BNEEX, JEX, JALEX, TRAP
    } state_e;

    state_e               state_q, state_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic [1:0]           cause_q, cause_d;

    logic       rdy;
    logic       wait_st;
    logic       memread, memwrite, iord;
    logic       irwrite, memsize, alusrca;
    logic [2:0] alusrcb;
    logic [1:0] aluop, pcsource;
    logic       regwrite, regdst, memtoreg;
    logic       link, bne, jmp;
    logic       pcwrite, pcwr_eq, pcwr_ne;

    assign rdy = (MEM_HANDSHAKE == 0) ? 1'b1
                                      : mem.mem_ready;

    assign wait_st = (state_q == FETCH) ||
                     (state_q == MEMRD) ||
                     (state_q == MEMWR);

    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        cause_d  = cause_q;
        memread  = 1'b0;
        memwrite = 1'b0;
        iord     = 1'b0;
        irwrite  = 1'b0;
        memsize  = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 3'b000;
        aluop    = 2'b00;
        pcsource = 2'b00;
        regwrite = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        link     = 1'b0;
        bne      = 1'b0;
        jmp      = 1'b0;
        pcwrite  = 1'b0;
        pcwr_eq  = 1'b0;
        pcwr_ne  = 1'b0;
        unique case (state_q)
            FETCH: begin
                memread = 1'b1;
                alusrcb = 3'b001;
                memsize = 1'b1;
                if (rdy) begin
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                alusrcb = 3'b011;
                case (op_i)
                    OP_R:    state_d = RTEX;
                    OP_ADDI: state_d = IMMEX;
                    OP_ANDI: state_d = IMMEX;
                    OP_ORI:  state_d = IMMEX;
                    OP_LB:   state_d = MEMADR;
                    OP_LW:   state_d = MEMADR;
                    OP_SB:   state_d = MEMADR;
                    OP_SW:   state_d = MEMADR;
                    OP_BEQ:  state_d = BEQEX;
                    OP_BNE:  state_d = BNEEX;
                    OP_J:    state_d = JEX;
                    OP_JAL:  state_d = JALEX;
                    default: begin
                        state_d = TRAP;
                        cause_d = CAUSE_ILL;
                    end
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 3'b010;
                // op[3] separates stores from loads
                state_d = op_i[3] ? MEMWR : MEMRD;
            end
            MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
                memsize = op_i[1];
                if (rdy) state_d = MEMWB;
            end
            MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                memsize  = op_i[1];
                state_d  = FETCH;
            end
            MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
                memsize  = op_i[1];
                if (rdy) state_d = FETCH;
            end
            RTEX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                state_d = RTWB;
            end
            RTWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
                state_d  = FETCH;
            end
            IMMEX: begin
                alusrca = 1'b1;
                if (op_i == OP_ADDI) begin
                    alusrcb = 3'b010;
                end else begin
                    alusrcb = 3'b100;
                    aluop   = 2'b11;
                end
                state_d = IMMWB;
            end
            IMMWB: begin
                regwrite = 1'b1;
                state_d  = FETCH;
            end
            BEQEX: begin
                alusrca  = 1'b1;
                aluop    = 2'b01;
                pcsource = 2'b01;
                pcwr_eq  = 1'b1;
                state_d  = FETCH;
            end
            BNEEX: begin
                alusrca  = 1'b1;
                aluop    = 2'b01;
                pcsource = 2'b01;
                pcwr_ne  = 1'b1;
                bne      = 1'b1;
                state_d  = FETCH;
            end
            JEX: begin
                pcsource = 2'b10;
                pcwrite  = 1'b1;
                jmp      = 1'b1;
                state_d  = FETCH;
            end
            JALEX: begin
                pcsource = 2'b10;
                pcwrite  = 1'b1;
                jmp      = 1'b1;
                regwrite = 1'b1;
                link     = 1'b1;
                state_d  = FETCH;
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
        // ready on the limit cycle still wins
        if (wait_st && !rdy) begin
            if (cnt_q == TMO) begin
                state_d = TRAP;
                cause_d = CAUSE_BUS;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= FETCH;
            cnt_q   <= '0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    assign mem.memread  = rst & memread;
    assign mem.memwrite = rst & memwrite;
    assign mem.iord     = rst & iord;
    assign mem.irwrite  = rst & irwrite;
    assign mem.memsize  = rst & memsize;

    assign alusrca_o  = rst & alusrca;
    assign alusrcb_o  = {3{rst}} & alusrcb;
    assign aluop_o    = {2{rst}} & aluop;
    assign pcsource_o = {2{rst}} & pcsource;
    assign regwrite_o = rst & regwrite;
    assign regdst_o   = rst & regdst;
    assign memtoreg_o = rst & memtoreg;
    assign link_o     = rst & link;
    assign bne_o      = rst & bne;
    assign j_o        = rst & jmp;
    assign trap_o     = rst & (state_q == TRAP);
    assign cause_o    = {2{rst}} & cause_q;

    assign pcen_o = rst & (pcwrite |
                           (pcwr_eq & zero_i) |
                           (pcwr_ne & ~zero_i));
endmodule
